// File: rtl/compress_pkg.sv
// Shared types and sizing for the compressed-line packing path.
package compress_pkg;

  localparam int unsigned CACHE_LINE_DEF     = 128;
  localparam int unsigned WORD_SIZE_DEF      = 64;
  localparam int unsigned WORDS_PER_LINE_DEF = 4;

  localparam int unsigned LEN_W   = 7;
  localparam int unsigned SUM_W   = 9;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned SHIFT_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAccum,
    StFlush,
    StFallback,
    StDone
  } state_e;

endpackage

// File: rtl/compress_line_sequencer_if.sv
// Handshake bundle between the compressor, the sequencer and the output word buffer.
interface compress_line_sequencer_if;
  import compress_pkg::*;

  logic               i_start;
  logic               i_len_valid;
  logic [LEN_W-1:0]   i_len;
  logic               o_len_ready;
  logic [SHIFT_W-1:0] o_shift_amount;
  logic               o_store;
  logic               o_store_pad;
  logic               i_out_ready;
  logic               o_raw_req;
  logic               o_line_done;
  logic               o_compressed;
  logic [SUM_W-1:0]   o_line_bits;
  logic               o_busy;

  modport slave (
    input  i_start, i_len_valid, i_len, i_out_ready,
    output o_len_ready, o_shift_amount, o_store, o_store_pad, o_raw_req,
           o_line_done, o_compressed, o_line_bits, o_busy
  );

  modport master (
    output i_start, i_len_valid, i_len, i_out_ready,
    input  o_len_ready, o_shift_amount, o_store, o_store_pad, o_raw_req,
           o_line_done, o_compressed, o_line_bits, o_busy
  );

endinterface

// File: rtl/compress_line_sequencer.sv
// Sequences per-word compressed lengths into bit offsets and 64-bit store requests,
// then closes the line as compressed or falls back to the raw path.
module compress_line_sequencer
  import compress_pkg::*;
#(
  parameter int unsigned CACHE_LINE     = CACHE_LINE_DEF,
  parameter int unsigned WORD_SIZE      = WORD_SIZE_DEF,
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input logic                      i_clk,
  input logic                      i_reset,
  compress_line_sequencer_if.slave bus
);

  localparam int unsigned      WordBits = $clog2(WORD_SIZE);
  localparam logic [SUM_W-1:0] LineMax  = SUM_W'(CACHE_LINE);
  localparam logic [LEN_W-1:0] WordMax  = LEN_W'(WORD_SIZE);
  localparam logic [CNT_W-1:0] LastCnt  = CNT_W'(WORDS_PER_LINE - 1);

  state_e           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d, new_sum;
  logic [SUM_W-1:0] line_bits_q, line_bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             store_q, store_d, pad_q, pad_d;
  logic             raw_q, raw_d, done_q, done_d, comp_q, comp_d, fail_q, fail_d;
  logic             len_ready, hs;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      sum_q       <= '0;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      pad_q       <= 1'b0;
      raw_q       <= 1'b0;
      done_q      <= 1'b0;
      comp_q      <= 1'b0;
      fail_q      <= 1'b0;
      line_bits_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      pad_q       <= pad_d;
      raw_q       <= raw_d;
      done_q      <= done_d;
      comp_q      <= comp_d;
      fail_q      <= fail_d;
      line_bits_q <= line_bits_d;
    end
  end

  assign new_sum = sum_q + SUM_W'(bus.i_len);
  assign hs      = bus.i_len_valid & len_ready;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    cnt_d       = cnt_q;
    fail_d      = fail_q;
    // A pending store survives until the buffer takes it.
    store_d     = store_q & ~bus.i_out_ready;
    pad_d       = pad_q & ~bus.i_out_ready;
    raw_d       = 1'b0;
    done_d      = 1'b0;
    comp_d      = 1'b0;
    line_bits_d = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.i_start) begin
          sum_d   = '0;
          cnt_d   = '0;
          fail_d  = 1'b0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (hs) begin
          if (bus.i_len > WordMax || new_sum > LineMax) begin
            state_d = StFallback;
          end else begin
            // Crossing a word boundary completes one full output word.
            if (new_sum[SUM_W-1:WordBits] != sum_q[SUM_W-1:WordBits]) begin
              store_d = 1'b1;
              pad_d   = 1'b0;
            end
            sum_d = new_sum;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LastCnt) begin
              state_d = (new_sum[WordBits-1:0] != '0) ? StFlush : StDone;
            end
          end
        end
      end
      StFlush: begin
        if (!store_q || bus.i_out_ready) begin
          store_d = 1'b1;
          pad_d   = 1'b1;
          state_d = StDone;
        end
      end
      StFallback: begin
        store_d = 1'b0;
        pad_d   = 1'b0;
        raw_d   = 1'b1;
        fail_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (!store_q || bus.i_out_ready) begin
          done_d      = 1'b1;
          comp_d      = ~fail_q;
          line_bits_d = fail_q ? '0 : sum_q;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_ready          = (state_q == StAccum) && !(store_q && !bus.i_out_ready);
    bus.o_len_ready    = len_ready;
    bus.o_shift_amount = SHIFT_W'(sum_q[WordBits-1:0]);
    bus.o_store        = store_q;
    bus.o_store_pad    = pad_q;
    bus.o_raw_req      = raw_q;
    bus.o_line_done    = done_q;
    bus.o_compressed   = comp_q;
    bus.o_line_bits    = line_bits_q;
    bus.o_busy         = (state_q != StIdle);
  end

endmodule

// File: tb/tb_compress_line_sequencer.sv
// Directed and randomized line sequences checked against a word-level packing model.
module tb_compress_line_sequencer;
  import compress_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  compress_line_sequencer_if bus ();

  compress_line_sequencer dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int lens[4];
  int hs_cyc[4];
  int n_hs, n_st, n_pad, n_raw, n_stall, n_stall_rdy, first_rise, done_cyc, d_comp, d_bits;
  bit done_seen;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({bus.o_store, bus.o_store_pad, bus.o_raw_req, bus.o_line_done,
                 bus.o_compressed, bus.o_busy, bus.o_len_ready, bus.o_line_bits,
                 bus.o_shift_amount});
  endfunction

  // mode 0: dense valid, ready high; 1: random valid/ready; 2: ready low in cycles 3..7
  task automatic run_line(input int mode);
    int  exp_sum, exp_acc, exp_st, cyc;
    bit  exp_abort;
    int  exp_shift[4];
    exp_sum   = 0;
    exp_acc   = 0;
    exp_st    = 0;
    exp_abort = 1'b0;
    exp_shift = '{0, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      if (!exp_abort) begin
        exp_shift[i] = exp_sum % WORD_SIZE_DEF;
        exp_acc++;
        if (lens[i] > WORD_SIZE_DEF || exp_sum + lens[i] > CACHE_LINE_DEF) begin
          exp_abort = 1'b1;
        end else begin
          if ((exp_sum + lens[i]) / WORD_SIZE_DEF != exp_sum / WORD_SIZE_DEF) exp_st++;
          exp_sum += lens[i];
        end
      end
    end

    n_hs = 0; n_st = 0; n_pad = 0; n_raw = 0; n_stall = 0; n_stall_rdy = 0;
    first_rise = -1; done_cyc = -1; d_comp = -1; d_bits = -1; done_seen = 1'b0;
    bus.i_start     = 1'b1;
    bus.i_len_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 200) begin
      bus.i_len_valid = (n_hs < 4) && (mode != 1 || $urandom_range(0, 3) != 0);
      bus.i_len       = LEN_W'(lens[(n_hs < 4) ? n_hs : 3]);
      if (mode == 1)      bus.i_out_ready = ($urandom_range(0, 2) != 0);
      else if (mode == 2) bus.i_out_ready = !(cyc >= 3 && cyc < 8);
      else                bus.i_out_ready = 1'b1;
      @(negedge clk);
      if (bus.i_len_valid && bus.o_len_ready) begin
        check_eq($sformatf("shift[%0d]", n_hs), int'(bus.o_shift_amount), exp_shift[n_hs]);
        hs_cyc[n_hs] = cyc;
        n_hs++;
      end
      if (bus.o_store && !bus.o_store_pad && first_rise < 0) first_rise = cyc;
      if (bus.o_store && !bus.i_out_ready) begin
        n_stall++;
        if (bus.o_len_ready) n_stall_rdy++;
      end
      if (bus.o_store && bus.i_out_ready) begin
        if (bus.o_store_pad) n_pad++;
        else                 n_st++;
      end
      if (bus.o_raw_req) n_raw++;
      if (bus.o_line_done) begin
        done_seen = 1'b1;
        done_cyc  = cyc;
        d_comp    = int'(bus.o_compressed);
        d_bits    = int'(bus.o_line_bits);
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.i_len_valid = 1'b0;
    bus.i_out_ready = 1'b1;

    check_eq("done_seen", int'(done_seen), 1);
    check_eq("accepted", n_hs, exp_acc);
    check_eq("stores", n_st, exp_st);
    check_eq("pad_stores", n_pad, (!exp_abort && (exp_sum % WORD_SIZE_DEF) != 0) ? 1 : 0);
    check_eq("raw_req", n_raw, exp_abort ? 1 : 0);
    check_eq("compressed", d_comp, exp_abort ? 0 : 1);
    check_eq("line_bits", d_bits, exp_abort ? 0 : exp_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int quiet;
    rst_n           = 1'b0;
    bus.i_start     = 1'b0;
    bus.i_len_valid = 1'b0;
    bus.i_len       = '0;
    bus.i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("reset_outs", outs_vec(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lens = '{20, 30, 40, 10};
    run_line(0);
    check_eq("t1_store_rise", first_rise, 4);
    check_eq("t1_done_cyc", done_cyc, 7);

    lens = '{32, 32, 32, 32};
    run_line(0);
    check_eq("t2_store_rise", first_rise, 3);
    check_eq("t2_done_cyc", done_cyc, 6);

    lens = '{64, 64, 1, 5};
    run_line(0);

    lens = '{60, 10, 5, 5};
    run_line(2);
    check_eq("t4_store_rise", first_rise, 3);
    check_eq("t4_stall_cycles", n_stall, 5);
    check_eq("t4_ready_in_stall", n_stall_rdy, 0);
    check_eq("t4_third_hs_cyc", hs_cyc[2], 8);

    lens = '{70, 0, 0, 0};
    run_line(0);

    // Reset while a store is pending in ACCUM.
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start     = 1'b0;
    bus.i_len_valid = 1'b1;
    bus.i_len       = LEN_W'(64);
    bus.i_out_ready = 1'b0;
    @(posedge clk); #1;
    bus.i_len_valid = 1'b0;
    @(negedge clk);
    check_eq("t6_store_pending", int'(bus.o_store), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("t6_outs_after_rst", outs_vec(), 0);
    quiet = 0;
    bus.i_out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_store || bus.o_line_done || bus.o_busy) quiet++;
    end
    check_eq("t6_quiet", quiet, 0);
    @(posedge clk); #1;
    lens = '{0, 0, 0, 0};
    run_line(0);
    check_eq("t6_zero_done_cyc", done_cyc, 6);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)     lens[i] = $urandom_range(65, 127);
        else if (r < 3) lens[i] = $urandom_range(40, 64);
        else            lens[i] = $urandom_range(0, 40);
      end
      run_line(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/compress_line_sequencer.md
# compress_line_sequencer

Control sequencer for the compressed-line packing path. It accepts the per-word compressed lengths of one cache line from the compressor, one handshake at a time. For each word it issues the bit offset at which the packing register must place that word, and it schedules each 64-bit store to the output word buffer. When the line is complete it either closes it as compressed (total ≤ CACHE_LINE bits) or aborts to the uncompressed fallback.

## Interface
- CACHE_LINE, 128, uncompressed line size in bits; compressed budget
- WORD_SIZE, 64, output store granularity in bits
- WORDS_PER_LINE, 4, source words per line
- i_clk  in  1  clock, rising edge
- i_reset  in  1  reset, active-low, synchronous
- i_start  in  1  begin a new line; honoured only in IDLE
- i_len_valid  in  1  compressed length available
- i_len  in  7  compressed length of the current word in bits, legal 0..WORD_SIZE
- o_len_ready  out  1  length accepted when high together with i_len_valid
- o_shift_amount  out  8  bit offset (sum mod WORD_SIZE) for the word being accepted; combinational, valid while o_len_ready
- o_store  out  1  store request for one full or padded 64-bit word; held until accepted
- o_store_pad  out  1  with o_store: partial word, pad upper bits
- i_out_ready  in  1  output buffer accepts o_store
- o_raw_req  out  1  one-cycle pulse requesting the uncompressed fallback for this line
- o_line_done  out  1  one-cycle pulse at line end
- o_compressed  out  1  qualifies o_line_done: 1 = packed line valid
- o_line_bits  out  9  total compressed bits of the finished line; valid with o_line_done
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCUM, FLUSH, FALLBACK, DONE.
- IDLE: on i_start, clear sum (9 bits) and cnt (2 bits), then go to ACCUM.
- ACCUM:
  - o_len_ready = !(o_store && !i_out_ready).
  - On handshake, new_sum = sum + i_len, computed at 9 bits with no wrap.
  - If i_len > WORD_SIZE or new_sum > CACHE_LINE: go to FALLBACK. No store is issued for this word.
  - Otherwise, if new_sum[8:6] != sum[8:6], set o_store (o_store_pad = 0).
  - sum <= new_sum, cnt <= cnt + 1.
  - On the last word (cnt == WORDS_PER_LINE-1): go to FLUSH if new_sum[5:0] != 0, else go to DONE.
  - A length of 0 is legal: it advances cnt and never stores.
- At most one store per handshake, since i_len ≤ WORD_SIZE.
- FLUSH:
  - Wait for any pending o_store to be accepted.
  - Then assert o_store with o_store_pad = 1 until i_out_ready, then go to DONE.
- FALLBACK:
  - Drop any pending o_store at the next edge.
  - Pulse o_raw_req, then go to DONE with o_compressed = 0 and o_line_bits = 0.
- DONE:
  - Wait until no o_store is pending.
  - Pulse o_line_done with o_compressed and o_line_bits = sum, then go to IDLE.
- i_start outside IDLE is ignored.
- i_len_valid outside ACCUM is ignored.

## Timing
- Every output is registered except o_len_ready and o_shift_amount.
- Reset values: all outputs 0; state IDLE; sum 0; cnt 0.
- Reset is synchronous. When i_reset is low at an edge, that edge returns the block to IDLE from any state, including with o_store pending. No store or done pulse follows.
- o_store rises one cycle after the crossing handshake.
- o_store falls on the edge where o_store && i_out_ready.
- A new length may be accepted in the same cycle a store is accepted.
- Best case: a line of 4 words, no padding, i_out_ready tied high, completes in 1 (start) + 4 + 1 (DONE) cycles.
- Padding adds one FLUSH cycle.

## Structure
- Shared package compress_pkg: state enum, CACHE_LINE, WORD_SIZE and WORDS_PER_LINE defaults, LEN_W = 7, SUM_W = 9.
- Single module; no sub-module.
- The boundary-crossing test (sum bits above log2(WORD_SIZE)) sits inline with the next-state logic.

## Test plan
- Lengths 20, 30, 40, 10, i_out_ready = 1:
  - o_shift_amount = 0, 20, 50, 26.
  - o_store one cycle after the third word.
  - FLUSH store with pad.
  - o_line_done with o_compressed = 1, o_line_bits = 100.
- Lengths 32, 32, 32, 32:
  - Stores after words 2 and 4.
  - No FLUSH.
  - o_line_bits = 128, compressed.
- Lengths 64, 64, 1:
  - Third handshake gives new_sum = 129.
  - FALLBACK, o_raw_req pulse, o_line_done with o_compressed = 0.
  - Fourth length is not accepted.
- Lengths 60, 10, with i_out_ready = 0 for 5 cycles after the store:
  - o_len_ready low for those cycles.
  - o_store held.
  - Third length accepted on the release cycle.
- i_len = 70 as the first word: immediate FALLBACK, o_line_bits = 0.
- i_reset low in ACCUM with o_store pending:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A following i_start with lengths 0, 0, 0, 0 gives o_line_bits = 0, compressed, no stores.
